alu_op_sequencer: RTL and testbench

Front-end controller for the 6-bit registered ALU. It captures operands A and B and opcode OP from a shared switch bus using edge-detected load strobes, and snapshots them on a start strobe. It then presents the snapshot to the ALU, waits out the ALU's registered latency, and captures the result. It reports completion with a one-cycle valid pulse and sits between the board I/O (switches/buttons) and the ALU instance.

---
 rtl/alu_op_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Front-end sequencer for a registered ALU: stages A/B/OP from a shared switch bus, issues a
// snapshot on start, waits out the ALU latency and captures the result. Define OP_CHECK_EN to
// reject illegal opcodes at start with a one-cycle o_err pulse.
module alu_op_sequencer #(
    parameter int unsigned N_BITS  = 6,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_BITS-1:0] i_sw,
    input  logic              i_btn_a,
    input  logic              i_btn_b,
    input  logic              i_btn_op,
    input  logic              i_start,
    input  logic [N_BITS-1:0] i_alu_res,
    output logic [N_BITS-1:0] o_alu_A,
    output logic [N_BITS-1:0] o_alu_B,
    output logic [N_BITS-1:0] o_alu_OP,
    output logic [N_BITS-1:0] o_result,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_err
);

    localparam int unsigned     CntW    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Strobe history, sampled every clock regardless of state
    logic btn_a_q, btn_b_q, btn_op_q, start_q;
    logic load_a, load_b, load_op, start_evt;

    logic [N_BITS-1:0] stg_a_q, stg_a_d;
    logic [N_BITS-1:0] stg_b_q, stg_b_d;
    logic [N_BITS-1:0] stg_op_q, stg_op_d;
    logic [N_BITS-1:0] alu_a_q, alu_a_d;
    logic [N_BITS-1:0] alu_b_q, alu_b_d;
    logic [N_BITS-1:0] alu_op_q, alu_op_d;
    logic [N_BITS-1:0] result_q, result_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

`ifdef OP_CHECK_EN
    logic err_q, err_d;

    function automatic logic op_legal(input logic [N_BITS-1:0] op);
        return (op == N_BITS'(6'b100000)) || (op == N_BITS'(6'b100010)) ||
               (op == N_BITS'(6'b100100)) || (op == N_BITS'(6'b100101)) ||
               (op == N_BITS'(6'b100110)) || (op == N_BITS'(6'b000011)) ||
               (op == N_BITS'(6'b000010)) || (op == N_BITS'(6'b100111));
    endfunction
`endif

    always_comb begin
        load_a    = i_btn_a  & ~btn_a_q;
        load_b    = i_btn_b  & ~btn_b_q;
        load_op   = i_btn_op & ~btn_op_q;
        start_evt = i_start  & ~start_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_a_q  <= 1'b0;
            btn_b_q  <= 1'b0;
            btn_op_q <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            btn_a_q  <= i_btn_a;
            btn_b_q  <= i_btn_b;
            btn_op_q <= i_btn_op;
            start_q  <= i_start;
        end
    end

    always_comb begin
        state_d  = state_q;
        stg_a_d  = stg_a_q;
        stg_b_d  = stg_b_q;
        stg_op_d = stg_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        result_d = result_q;
        cnt_d    = cnt_q;
`ifdef OP_CHECK_EN
        err_d    = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (load_a)  stg_a_d  = i_sw;
                if (load_b)  stg_b_d  = i_sw;
                if (load_op) stg_op_d = i_sw;
                // Snapshot reads the _q staging, so a same-cycle load is not seen here
                if (start_evt) begin
`ifdef OP_CHECK_EN
                    if (!op_legal(stg_op_q)) begin
                        err_d = 1'b1;
                    end else begin
                        alu_a_d  = stg_a_q;
                        alu_b_d  = stg_b_q;
                        alu_op_d = stg_op_q;
                        state_d  = StIssue;
                    end
`else
                    alu_a_d  = stg_a_q;
                    alu_b_d  = stg_b_q;
                    alu_op_d = stg_op_q;
                    state_d  = StIssue;
`endif
                end
            end
            StIssue: begin
                cnt_d   = CntLoad;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    result_d = i_alu_res;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            stg_a_q  <= '0;
            stg_b_q  <= '0;
            stg_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            stg_a_q  <= stg_a_d;
            stg_b_q  <= stg_b_d;
            stg_op_q <= stg_op_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef OP_CHECK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    assign o_alu_A  = alu_a_q;
    assign o_alu_B  = alu_b_q;
    assign o_alu_OP = alu_op_q;
    assign o_result = result_q;
    assign o_valid  = (state_q == StDone);
    assign o_busy   = (state_q != StIdle);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios plus randomized operations,
// compared against a transaction-level model of staging, snapshot and result.
module tb_alu_op_sequencer;

    localparam int unsigned N_BITS  = 6;
    localparam int unsigned ALU_LAT = 1;
    localparam int          OpLat   = ALU_LAT + 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] i_sw;
    logic       i_btn_a, i_btn_b, i_btn_op, i_start;
    logic [5:0] i_alu_res;
    logic [5:0] o_alu_A, o_alu_B, o_alu_OP, o_result;
    logic       o_valid, o_busy, o_err;

    int checks   = 0;
    int failures = 0;

    // Model: staging registers, last issued snapshot, last captured result
    logic [5:0] m_a, m_b, m_op;
    logic [5:0] m_alu_a, m_alu_b, m_alu_op, m_res;

    alu_op_sequencer #(
        .N_BITS  (N_BITS),
        .ALU_LAT (ALU_LAT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .i_sw      (i_sw),
        .i_btn_a   (i_btn_a),
        .i_btn_b   (i_btn_b),
        .i_btn_op  (i_btn_op),
        .i_start   (i_start),
        .i_alu_res (i_alu_res),
        .o_alu_A   (o_alu_A),
        .o_alu_B   (o_alu_B),
        .o_alu_OP  (o_alu_OP),
        .o_result  (o_result),
        .o_valid   (o_valid),
        .o_busy    (o_busy),
        .o_err     (o_err)
    );

    always #5 clock = ~clock;

    function automatic logic [5:0] alu_ref(input logic [5:0] a, input logic [5:0] b,
                                           input logic [5:0] op);
        logic signed [5:0] sa;
        sa = a;
        case (op)
            6'b100000: return a + b;
            6'b100010: return a - b;
            6'b100100: return a & b;
            6'b100101: return a | b;
            6'b100110: return a ^ b;
            6'b000011: return sa >>> b;
            6'b000010: return a >> b;
            6'b100111: return ~(a | b);
            default:   return 6'd0;
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                          6'b100110, 6'b000011, 6'b000010, 6'b100111};
    endfunction

    // Behavioural registered ALU with ALU_LAT stages
    logic [5:0] alu_pipe [ALU_LAT];
    always @(posedge clock) begin
        alu_pipe[0] <= alu_ref(o_alu_A, o_alu_B, o_alu_OP);
        for (int i = 1; i < int'(ALU_LAT); i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign i_alu_res = alu_pipe[ALU_LAT-1];

    task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk1({tag, "_busy"}, o_busy, 1'b0);
        chk1({tag, "_valid"}, o_valid, 1'b0);
        chk1({tag, "_err"}, o_err, 1'b0);
        chk6({tag, "_alu_a"}, o_alu_A, m_alu_a);
        chk6({tag, "_alu_b"}, o_alu_B, m_alu_b);
        chk6({tag, "_alu_op"}, o_alu_OP, m_alu_op);
        chk6({tag, "_result"}, o_result, m_res);
    endtask

    task automatic clear_model();
        m_a = 0; m_b = 0; m_op = 0;
        m_alu_a = 0; m_alu_b = 0; m_alu_op = 0; m_res = 0;
    endtask

    // which: 0=A 1=B 2=OP; button high one cycle then low one cycle
    task automatic load(input int which, input logic [5:0] val);
        i_sw = val;
        case (which)
            0: begin i_btn_a = 1'b1; m_a = val; end
            1: begin i_btn_b = 1'b1; m_b = val; end
            default: begin i_btn_op = 1'b1; m_op = val; end
        endcase
        @(negedge clock);
        i_btn_a = 1'b0; i_btn_b = 1'b0; i_btn_op = 1'b0;
        @(negedge clock);
    endtask

    // Start edge (optionally with same-cycle loads), then check every cycle of the operation
    task automatic start_op(input int hold, input bit disturb, input logic [2:0] ld_mask,
                            input logic [5:0] ld_val);
        bit issue;
`ifdef OP_CHECK_EN
        issue = is_legal(m_op);
`else
        issue = 1'b1;
`endif
        if (issue) begin
            m_alu_a = m_a; m_alu_b = m_b; m_alu_op = m_op;
            m_res = alu_ref(m_a, m_b, m_op);
        end
        i_sw = ld_val;
        i_btn_a = ld_mask[0]; i_btn_b = ld_mask[1]; i_btn_op = ld_mask[2];
        i_start = 1'b1;
        if (ld_mask[0]) m_a = ld_val;
        if (ld_mask[1]) m_b = ld_val;
        if (ld_mask[2]) m_op = ld_val;
        for (int k = 1; k <= OpLat + 1; k++) begin
            @(negedge clock);
            chk1("op_busy", o_busy, issue && (k <= OpLat));
            chk1("op_valid", o_valid, issue && (k == OpLat));
            chk1("op_err", o_err, !issue && (k == 1));
            chk6("op_alu_a", o_alu_A, m_alu_a);
            chk6("op_alu_b", o_alu_B, m_alu_b);
            chk6("op_alu_op", o_alu_OP, m_alu_op);
            if (!issue || k >= OpLat) chk6("op_result", o_result, m_res);
            if (k == 1) begin i_btn_a = 1'b0; i_btn_b = 1'b0; i_btn_op = 1'b0; end
            if (k >= hold) i_start = 1'b0;
            if (disturb && k == 1) begin i_sw = ~m_a; i_btn_a = 1'b1; end
            if (disturb && k == 2) begin i_btn_a = 1'b0; i_start = 1'b1; end
            if (disturb && k == 3) i_start = 1'b0;
        end
        for (int k = OpLat + 2; k <= hold; k++) begin
            @(negedge clock);
            chk_idle("hold");
            if (k == hold) i_start = 1'b0;
        end
        @(negedge clock);
        chk_idle("post_op");
    endtask

    task automatic load_abo(input logic [5:0] a, input logic [5:0] b, input logic [5:0] op);
        load(0, a);
        load(1, b);
        load(2, op);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] legal_ops [8];
        logic [5:0] ra, rb, rop;
        legal_ops = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                      6'b100110, 6'b000011, 6'b000010, 6'b100111};
        reset = 1'b1;
        i_sw = 0; i_btn_a = 0; i_btn_b = 0; i_btn_op = 0; i_start = 0;
        clear_model();
        repeat (2) @(negedge clock);
        chk_idle("reset");
        reset = 1'b0;
        @(negedge clock);

        // ADD 5+3
        load_abo(6'd5, 6'd3, 6'b100000);
        start_op(1, 1'b0, 3'b000, 6'd0);
        chk6("add_lit", o_result, 6'd8);

        // SUB 3-5 wraps, then AND
        load_abo(6'd3, 6'd5, 6'b100010);
        start_op(1, 1'b0, 3'b000, 6'd0);
        chk6("sub_lit", o_result, 6'd62);
        load_abo(6'b101010, 6'b110011, 6'b100100);
        start_op(1, 1'b0, 3'b000, 6'd0);
        chk6("and_lit", o_result, 6'b100010);

        // Loads and start during busy are ignored; staging A survives
        load_abo(6'd17, 6'd9, 6'b100101);
        start_op(1, 1'b1, 3'b000, 6'd0);
        start_op(1, 1'b0, 3'b000, 6'd0);
        chk6("staging_a_kept", o_alu_A, 6'd17);

        // Held start: one operation only
        load_abo(6'd20, 6'd7, 6'b100000);
        start_op(10, 1'b0, 3'b000, 6'd0);

        // Same-cycle load and start: snapshot uses pre-load staging
        start_op(1, 1'b0, 3'b011, 6'd44);
        start_op(1, 1'b0, 3'b000, 6'd0);
        chk6("post_load_a", o_alu_A, 6'd44);

        // Reset during WAIT aborts without o_valid
        load_abo(6'd11, 6'd12, 6'b100110);
        i_start = 1'b1;
        @(negedge clock);
        i_start = 1'b0;
        chk1("rst_issue_busy", o_busy, 1'b1);
        @(negedge clock);
        chk1("rst_wait_busy", o_busy, 1'b1);
        reset = 1'b1;
        #1;
        clear_model();
        chk_idle("rst_async");
        @(negedge clock);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk_idle("rst_after");
        end
        load_abo(6'd30, 6'd2, 6'b000010);
        start_op(1, 1'b0, 3'b000, 6'd0);

        // Illegal opcode
        load(2, 6'b111111);
        start_op(1, 1'b0, 3'b000, 6'd0);
        load(2, 6'b100111);
        start_op(1, 1'b0, 3'b000, 6'd0);

        // Randomized operations
        for (int n = 0; n < 30; n++) begin
            ra  = 6'($urandom);
            rb  = 6'($urandom);
            rop = legal_ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 3) != 0) load(0, ra);
            if ($urandom_range(0, 3) != 0) load(2, rop);
            if ($urandom_range(0, 3) != 0) load(1, rb);
            if ($urandom_range(0, 3) == 0)
                start_op(1, 1'b0, 3'($urandom_range(1, 7)), 6'($urandom));
            else
                start_op(1, 1'b0, 3'b000, 6'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
